// File: rtl/tc0480scp_rom_cache_if.sv
// Bundles the tile-ROM client port and the SDRAM miss port of tc0480scp_rom_cache.
// The master view belongs to the client/SDRAM side; the slave view belongs to the cache.
interface tc0480scp_rom_cache_if;
   logic [20:0] rom_address;
   logic        rom_req;
   logic        rom_ack;
   logic [63:0] rom_data;
   logic        flush;
   logic [26:0] sdr_addr;
   logic        sdr_req;
   logic        sdr_ack;
   logic [63:0] sdr_data;

   modport master (
      output rom_address, rom_req, flush, sdr_ack, sdr_data,
      input  rom_ack, rom_data, sdr_addr, sdr_req
   );

   modport slave (
      input  rom_address, rom_req, flush, sdr_ack, sdr_data,
      output rom_ack, rom_data, sdr_addr, sdr_req
   );
endinterface

// File: rtl/tc0480scp_rom_cache.sv
// Small fully-associative 64-bit word cache in front of the TC0480SCP tile ROM port.
// Defining TC0480SCP_ROM_CACHE_STATS_EN adds the saturating hit_count/miss_count outputs.
//
// state        | meaning
// IDLE         | waiting for a pending client request; hits are answered from here
// MISS_ISSUE   | drive the SDRAM address and toggle sdr_req
// MISS_WAIT    | wait for sdr_ack == sdr_req, then fill the entry and answer the client
module tc0480scp_rom_cache #(
   parameter int          ENTRIES  = 4,
   parameter logic [26:0] ROM_BASE = 27'h0
) (
   input  logic clk,
   input  logic reset,
   tc0480scp_rom_cache_if.slave bus
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);
   localparam int PW = $clog2(ENTRIES);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_MISS_ISSUE = 2'd1;
   localparam logic [1:0] S_MISS_WAIT  = 2'd2;

   logic [1:0]         state;
   logic [ENTRIES-1:0] valid;
   logic [20:0]        tag_mem  [ENTRIES];
   logic [63:0]        data_mem [ENTRIES];
   logic [PW-1:0]      ptr;
   logic [20:0]        req_addr;
   logic               flush_pend;
   logic               rom_ack_q;
   logic [63:0]        rom_data_q;
   logic               sdr_req_q;
   logic [26:0]        sdr_addr_q;

   logic          pending;
   logic          hit;
   logic [PW-1:0] hit_idx;
   logic          fill;

   assign bus.rom_ack  = rom_ack_q;
   assign bus.rom_data = rom_data_q;
   assign bus.sdr_req  = sdr_req_q;
   assign bus.sdr_addr = sdr_addr_q;

   assign pending = (state == S_IDLE) && (bus.rom_req != rom_ack_q);
   assign fill    = (state == S_MISS_WAIT) && (bus.sdr_ack == sdr_req_q);

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && tag_mem[i] == bus.rom_address) begin
            hit     = 1'b1;
            hit_idx = i[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         valid      <= '0;
         ptr        <= '0;
         req_addr   <= '0;
         flush_pend <= 1'b0;
         rom_ack_q  <= 1'b0;
         rom_data_q <= '0;
         sdr_req_q  <= 1'b0;
         sdr_addr_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pending) begin
                  req_addr <= bus.rom_address;
                  if (hit) begin
                     rom_data_q <= data_mem[hit_idx];
                     rom_ack_q  <= bus.rom_req;
                  end else begin
                     state <= S_MISS_ISSUE;
                  end
               end
            end
            S_MISS_ISSUE: begin
               sdr_addr_q <= ROM_BASE + {req_addr, 3'b000};
               sdr_req_q  <= ~sdr_req_q;
               state      <= S_MISS_WAIT;
            end
            S_MISS_WAIT: begin
               if (fill) begin
                  // a flush seen at any point of the miss leaves the new entry invalid
                  valid[ptr] <= ~(bus.flush | flush_pend);
                  rom_data_q <= bus.sdr_data;
                  rom_ack_q  <= bus.rom_req;
                  ptr        <= ptr + 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (bus.flush)
            valid <= '0;

         if (state == S_IDLE)
            flush_pend <= 1'b0;
         else if (bus.flush)
            flush_pend <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[ptr]  <= req_addr;
         data_mem[ptr] <= bus.sdr_data;
      end
   end

`ifdef TC0480SCP_ROM_CACHE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (bus.flush) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (pending) begin
         if (hit) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
         end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_tc0480scp_rom_cache.sv
// Directed bench for tc0480scp_rom_cache: a transaction-level cache model drives the
// expected port values, checked every negedge, plus literal spot checks.
module tb_tc0480scp_rom_cache;
   logic clk = 1'b0;
   logic reset = 1'b1;

   tc0480scp_rom_cache_if bus ();
   tc0480scp_rom_cache_if bus_b ();

`ifdef TC0480SCP_ROM_CACHE_STATS_EN
   logic [15:0] hit_count, miss_count, hit_count_b, miss_count_b;
`endif

   tc0480scp_rom_cache #(.ENTRIES(4), .ROM_BASE(27'h0)) dut (
      .clk(clk), .reset(reset), .bus(bus)
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   tc0480scp_rom_cache #(.ENTRIES(4), .ROM_BASE(27'h0400000)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
      , .hit_count(hit_count_b), .miss_count(miss_count_b)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [26:0] BASE = 27'h0;

   int n_checks = 0;
   int n_fail   = 0;
   bit running  = 0;

   logic        exp_ack;
   logic [63:0] exp_data;
   logic        exp_sreq;
   logic [26:0] exp_saddr;

   logic [20:0] m_tag  [4];
   logic [63:0] m_data [4];
   bit          m_val  [4];
   int          m_ptr;
   int          m_hits, m_misses;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_val[i] = 0;
   endtask

   function automatic int model_lookup(input logic [20:0] a);
      for (int i = 0; i < 4; i++)
         if (m_val[i] && m_tag[i] == a) return i;
      return -1;
   endfunction

   function automatic logic [63:0] dat(input logic [20:0] a);
      return 64'hA5A5_0000_0000_0000 | 64'(a);
   endfunction

   always @(negedge clk) begin
      if (running) begin
         chk("rom_ack",  64'(bus.rom_ack),  64'(exp_ack));
         chk("rom_data", bus.rom_data,      exp_data);
         chk("sdr_req",  64'(bus.sdr_req),  64'(exp_sreq));
         chk("sdr_addr", 64'(bus.sdr_addr), 64'(exp_saddr));
      end
   end

   // One client transaction; on a miss the bench plays SDRAM and answers after lat cycles.
   task automatic request(input logic [20:0] a, input logic [63:0] d, input int lat,
                          input bit flush_mid);
      int idx;
      bit flushed;
      @(negedge clk);
      bus.rom_address = a;
      bus.rom_req     = ~bus.rom_req;
      idx = model_lookup(a);
      if (idx >= 0) begin
         @(posedge clk);
         exp_ack  = bus.rom_req;
         exp_data = m_data[idx];
         m_hits++;
      end else begin
         m_misses++;
         @(posedge clk);
         @(posedge clk);
         exp_sreq  = ~exp_sreq;
         exp_saddr = 27'(BASE + {a, 3'b000});
         flushed   = 0;
         for (int k = 0; k < lat - 1; k++) begin
            @(negedge clk);
            if (flush_mid && k == 0) begin
               bus.flush = 1'b1;
               flushed   = 1;
               model_clear();
               m_hits   = 0;
               m_misses = 0;
            end else begin
               bus.flush = 1'b0;
            end
         end
         @(negedge clk);
         bus.flush    = 1'b0;
         bus.sdr_data = d;
         bus.sdr_ack  = exp_sreq;
         @(posedge clk);
         exp_ack       = bus.rom_req;
         exp_data      = d;
         m_tag[m_ptr]  = a;
         m_data[m_ptr] = d;
         m_val[m_ptr]  = !flushed;
         m_ptr         = (m_ptr + 1) % 4;
      end
   endtask

   initial begin
      bus.rom_address = '0; bus.rom_req = 1'b0; bus.flush = 1'b0;
      bus.sdr_ack = 1'b0;   bus.sdr_data = '0;
      bus_b.rom_address = '0; bus_b.rom_req = 1'b0; bus_b.flush = 1'b0;
      bus_b.sdr_ack = 1'b0;   bus_b.sdr_data = '0;
      exp_ack = 1'b0; exp_data = '0; exp_sreq = 1'b0; exp_saddr = '0;
      model_clear();
      m_ptr = 0; m_hits = 0; m_misses = 0;

      #2;
      chk("reset rom_ack",  64'(bus.rom_ack),  64'd0);
      chk("reset rom_data", bus.rom_data,      64'd0);
      chk("reset sdr_req",  64'(bus.sdr_req),  64'd0);
      chk("reset sdr_addr", 64'(bus.sdr_addr), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b0;
      running = 1;

      // cold miss then hit
      request(21'h00010, 64'h0123_4567_89AB_CDEF, 5, 0);
      #1;
      chk("cold rom_data", bus.rom_data, 64'h0123_4567_89AB_CDEF);
      chk("cold sdr_addr", 64'(bus.sdr_addr), 64'h80);
      chk("cold rom_ack",  64'(bus.rom_ack), 64'd1);
      request(21'h00010, 64'h0, 0, 0);
      #1;
      chk("hit rom_data", bus.rom_data, 64'h0123_4567_89AB_CDEF);
      chk("hit rom_ack",  64'(bus.rom_ack), 64'd0);
      chk("hit no sdr_req toggle", 64'(bus.sdr_req), 64'd1);

      // replacement: 0x14 evicts 0x10 from entry 0
      for (int a = 'h11; a <= 'h14; a++) request(21'(a), dat(21'(a)), 3, 0);
      request(21'h00011, 64'h0, 0, 0);
      #1;
      chk("repl 0x11 hit data", bus.rom_data, 64'hA5A5_0000_0000_0011);
      request(21'h00010, 64'hFEED_0000_0000_0010, 2, 0);
      #1;
      chk("repl 0x10 miss sdr_addr", 64'(bus.sdr_addr), 64'h80);
      chk("repl 0x10 data", bus.rom_data, 64'hFEED_0000_0000_0010);

      // flush during MISS_WAIT
      request(21'h00020, 64'h2020_2020_2020_2020, 4, 1);
      #1;
      chk("flush fill data", bus.rom_data, 64'h2020_2020_2020_2020);
      request(21'h00020, 64'h2121_2121_2121_2121, 2, 0);
      #1;
      chk("flush re-miss sdr_addr", 64'(bus.sdr_addr), 64'h100);
      request(21'h00012, 64'h1212_0000_0000_0012, 2, 0);
      request(21'h00020, 64'h0, 0, 0);

      // base offset instance
      @(negedge clk);
      bus_b.rom_address = 21'h1FFFFF;
      bus_b.rom_req     = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("base sdr_addr", 64'(bus_b.sdr_addr), 64'h13FFFF8);
      chk("base sdr_req",  64'(bus_b.sdr_req),  64'd1);

      // async reset in MISS_WAIT
      @(negedge clk);
      bus.rom_address = 21'h00030;
      bus.rom_req     = ~bus.rom_req;
      m_misses++;
      @(posedge clk);
      @(posedge clk);
      exp_sreq  = ~exp_sreq;
      exp_saddr = 27'h180;
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      bus.rom_req = 1'b0;
      exp_ack = 1'b0; exp_data = '0; exp_sreq = 1'b0; exp_saddr = '0;
      model_clear();
      m_ptr = 0; m_hits = 0; m_misses = 0;
      #1;
      chk("async rom_ack",  64'(bus.rom_ack),  64'd0);
      chk("async sdr_req",  64'(bus.sdr_req),  64'd0);
      chk("async rom_data", bus.rom_data,      64'd0);
      @(negedge clk);
      reset        = 1'b0;
      bus.sdr_data = 64'hDEAD_BEEF_DEAD_BEEF;
      bus.sdr_ack  = ~bus.sdr_ack;
      repeat (4) @(negedge clk);
      reset       = 1'b1;
      bus.sdr_ack = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      request(21'h00010, 64'h1010_1010_1010_1010, 3, 0);
      #1;
      chk("post-reset 0x10 miss sdr_addr", 64'(bus.sdr_addr), 64'h80);
      request(21'h00010, 64'h0, 0, 0);
      @(negedge clk);

`ifdef TC0480SCP_ROM_CACHE_STATS_EN
      chk("hit_count",  64'(hit_count),  64'(m_hits));
      chk("miss_count", 64'(miss_count), 64'(m_misses));
`endif
      running = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
